// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the fifo word reader
package fifo_rd_pkg;

    localparam int FIFO_DW = 8;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_word_reader_word_pack.sv
// rtl/fifo_word_reader_word_pack.sv - byte lane registers for one packed output word
// Ports:
//   rd_clk, reset_n      clock, asynchronous active-low reset
//   i_clear              zero every lane (wins over a write)
//   i_wr_en, i_wr_idx    write i_wr_data into lane i_wr_idx
//   o_data               all lanes, lane k in bits [8k+7:8k]
module word_pack
    import fifo_rd_pkg::*;
#(
    parameter int WORD_BYTES = 2
) (
    input  logic                          rd_clk,
    input  logic                          reset_n,
    input  logic                          i_clear,
    input  logic                          i_wr_en,
    input  logic [2:0]                    i_wr_idx,
    input  logic [FIFO_DW-1:0]            i_wr_data,
    output logic [FIFO_DW*WORD_BYTES-1:0] o_data
);

    logic [FIFO_DW-1:0] r_lane [WORD_BYTES];

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WORD_BYTES; k++) r_lane[k] <= '0;
        end else if (i_clear) begin
            for (int k = 0; k < WORD_BYTES; k++) r_lane[k] <= '0;
        end else if (i_wr_en) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (i_wr_idx == 3'(k)) r_lane[k] <= i_wr_data;
            end
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
        assign o_data[g*FIFO_DW +: FIFO_DW] = r_lane[g];
    end

endmodule

// File: rtl/fifo_word_reader.sv
// rtl/fifo_word_reader.sv - pops bytes from an 8-bit fifo and presents packed words
// Ports:
//   rd_clk, reset_n              read clock, asynchronous active-low reset
//   fifo_empty, fifo_data        fifo status and registered read data (valid the cycle after a pop)
//   fifo_rd                      fifo pop request
//   m_data, m_valid, m_ready     packed word handshake, first popped byte in lane 0
//   m_bytes                      number of valid lanes in m_data
//   flush                        emit the partially gathered word
//   words_out                    wrapping count of accepted words
module fifo_word_reader
    import fifo_rd_pkg::*;
#(
    parameter int WORD_BYTES = 2
) (
    input  logic                          rd_clk,
    input  logic                          reset_n,
    input  logic                          fifo_empty,
    input  logic [FIFO_DW-1:0]            fifo_data,
    output logic                          fifo_rd,
    output logic [FIFO_DW*WORD_BYTES-1:0] m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2:0]                    m_bytes,
    input  logic                          flush,
    output logic [15:0]                   words_out
);

    localparam logic [2:0] W_FULL = 3'(WORD_BYTES);

    rd_state_t   r_state;
    logic [2:0]  r_captured;
    logic [2:0]  r_issued;
    logic        r_inflight;
    logic        r_flush_pend;
    logic        r_m_valid;
    logic [2:0]  r_m_bytes;
    logic [15:0] r_words_out;

    logic        w_pop;
    logic        w_capture;
    logic [2:0]  w_cap_next;
    logic        w_handshake;
    logic        w_flush_now;
    logic        w_flush_defer;
    logic        w_emit;

    // Gated by reset_n so no pop can reach the fifo while the block is held in reset.
    assign w_pop       = reset_n && (r_state == FILL) && !fifo_empty
                         && (r_issued < W_FULL) && !r_flush_pend;
    assign w_capture   = (r_state == FILL) && r_inflight;
    assign w_cap_next  = r_captured + 3'(w_capture);
    assign w_handshake = (r_state == OUT) && m_ready;

    // A pop issued on the same edge as flush counts as in flight: its byte
    // arrives next cycle and must land in this word, so emission is deferred.
    assign w_flush_now   = (r_state == FILL) && flush && !r_inflight && !w_pop
                           && (r_captured != 3'd0);
    assign w_flush_defer = (r_state == FILL) && flush && (r_inflight || w_pop);

    // With flush pending no new pops are issued, so the edge after it was set
    // either captures the last outstanding byte or has nothing left to wait for.
    assign w_emit = (w_capture && (w_cap_next == W_FULL)) || r_flush_pend || w_flush_now;

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= FILL;
            r_captured   <= '0;
            r_issued     <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_bytes    <= '0;
            r_words_out  <= '0;
        end else if (r_state == FILL) begin
            r_inflight <= w_pop;
            if (w_pop)     r_issued   <= r_issued + 3'd1;
            if (w_capture) r_captured <= w_cap_next;
            if (w_emit) begin
                r_state      <= OUT;
                r_m_valid    <= 1'b1;
                r_m_bytes    <= w_cap_next;
                r_flush_pend <= 1'b0;
            end else if (w_flush_defer) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            if (m_ready) begin
                r_state     <= FILL;
                r_m_valid   <= 1'b0;
                r_m_bytes   <= '0;
                r_captured  <= '0;
                r_issued    <= '0;
                r_words_out <= r_words_out + 16'd1;
            end
        end
    end

    word_pack #(
        .WORD_BYTES (WORD_BYTES)
    ) u_word_pack (
        .rd_clk    (rd_clk),
        .reset_n   (reset_n),
        .i_clear   (w_handshake),
        .i_wr_en   (w_capture),
        .i_wr_idx  (r_captured),
        .i_wr_data (fifo_data),
        .o_data    (m_data)
    );

    assign fifo_rd   = w_pop;
    assign m_valid   = r_m_valid;
    assign m_bytes   = r_m_bytes;
    assign words_out = r_words_out;

endmodule

// File: tb/tb_fifo_word_reader.sv
// tb/tb_fifo_word_reader.sv - self-checking bench for fifo_word_reader
module tb_fifo_word_reader;

    logic        rd_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  m_bytes;
    logic        flush = 1'b0;
    logic [15:0] words_out;

    fifo_word_reader #(.WORD_BYTES(2)) dut (
        .rd_clk     (rd_clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_bytes    (m_bytes),
        .flush      (flush),
        .words_out  (words_out)
    );

    always #5 rd_clk = ~rd_clk;

    // fifo model: registered data_out, byte appears the cycle after the pop edge
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int viol = 0;
    always @(negedge rd_clk) begin
        if (fifo_rd && fifo_empty) viol++;
    end

    typedef struct {
        logic [15:0] data;
        logic [2:0]  bytes;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          hold;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[5];

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_words = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    // Wait for a word, check it stays stable for hold cycles, then accept it
    // and compare against the scoreboard head.
    task automatic take_word(input int hold);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge rd_clk);
            ok = m_valid;
        end
        if (!ok) begin
            check("word_timeout", 32'(m_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_word", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb[0];
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(e.data));
            check("hold_fifo_rd", 32'(fifo_rd), 32'd0);
            @(negedge rd_clk);
        end
        if (!m_ready) begin
            tick();
            m_ready = 1'b1;
            @(negedge rd_clk);
        end
        e = sb.pop_front();
        check("word_valid", 32'(m_valid), 32'd1);
        check("word_data", 32'(m_data), 32'(e.data));
        check("word_bytes", 32'(m_bytes), 32'(e.bytes));
        tick();
        exp_words = exp_words + 16'd1;
        check("words_out", 32'(words_out), 32'(exp_words));
        check("valid_drop", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int p0;

        vecs[0] = '{8'h11, 8'h22, 0,  16'h2211};
        vecs[1] = '{8'h33, 8'h44, 0,  16'h4433};
        vecs[2] = '{8'hA5, 8'h5A, 10, 16'h5AA5};
        vecs[3] = '{8'h00, 8'hFF, 2,  16'hFF00};
        vecs[4] = '{8'hC3, 8'h3C, 0,  16'h3CC3};

        // reset state
        repeat (3) tick();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_bytes", 32'(m_bytes), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        reset_n = 1'b1;

        // table vectors; first two share a preloaded fifo with m_ready held high
        push(vecs[0].b0); push(vecs[0].b1); push(vecs[1].b0); push(vecs[1].b1);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                m_ready = (vecs[i].hold == 0);
                push(vecs[i].b0);
                push(vecs[i].b1);
            end
            sb.push_back('{vecs[i].exp, 3'd2});
            take_word(vecs[i].hold);
            if (i == 1) check("no_pop_when_empty_a", 32'(viol), 32'd0);
        end

        // flush with nothing gathered is ignored
        tick(); flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) @(negedge rd_clk);
        check("flush_empty_ignored", 32'(m_valid), 32'd0);

        // single byte, flush after the capture has landed
        m_ready = 1'b0;
        push(8'h7E);
        repeat (3) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        sb.push_back('{16'h007E, 3'd1});
        take_word(2);

        // single byte, flush in the cycle after the pop (byte still in flight)
        m_ready = 1'b0;
        p0 = rd_ptr;
        push(8'h7E);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        sb.push_back('{16'h007E, 3'd1});
        take_word(1);
        check("flush_inflight_pops", 32'(rd_ptr - p0), 32'd1);

        // empty gap mid-word
        push(8'h01);
        repeat (6) tick();
        push(8'h02);
        sb.push_back('{16'h0201, 3'd2});
        take_word(0);
        check("no_pop_when_empty_b", 32'(viol), 32'd0);

        // reset while holding a word
        m_ready = 1'b0;
        push(8'hEF); push(8'hBE);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge rd_clk);
            ok = m_valid;
        end
        check("beef_data", 32'(m_data), 32'h0000BEEF);
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_data", 32'(m_data), 32'd0);
        check("rst_mid_words", 32'(words_out), 32'd0);
        check("rst_mid_bytes", 32'(m_bytes), 32'd0);
        tick();
        reset_n = 1'b1;
        exp_words = 16'h0000;
        push(8'h12); push(8'h34);
        sb.push_back('{16'h3412, 3'd2});
        take_word(1);

        // words_out wrap
        force dut.r_words_out = 16'hFFFF;
        tick();
        release dut.r_words_out;
        #1;
        check("words_preload", 32'(words_out), 32'h0000FFFF);
        exp_words = 16'hFFFF;
        push(8'hAB); push(8'hCD);
        sb.push_back('{16'hCDAB, 3'd2});
        take_word(0);

        check("no_pop_when_empty_c", 32'(viol), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_word_reader.md
FIFO_WORD_READER -- requirements
Module: fifo_word_reader

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 2, meaning bytes packed per output word (legal range 2..4).
REQ-002 The block SHALL use reset reset_n, asynchronous, active-low; clock rd_clk.
REQ-003 Port rd_clk  input  1  read-domain clock shared with the 8x8 fifo read side.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port fifo_empty  input  1  fifo empty flag.
REQ-006 Port fifo_data  input  8  fifo registered data_out.
REQ-007 Port fifo_rd  output  1  fifo read enable.
REQ-008 Port m_data  output  8*WORD_BYTES  packed word; byte k in bits [8k+7:8k]; first-popped byte in lane 0.
REQ-009 Port m_valid  output  1  word valid.
REQ-010 Port m_ready  input  1  downstream accept.
REQ-011 Port m_bytes  output  3  count of valid lanes in m_data (1..WORD_BYTES).
REQ-012 Port flush  input  1  single-cycle request to emit a partial word.
REQ-013 Port words_out  output  16  count of accepted words.

Function
REQ-014 Fifo timing contract: a pop sampled at edge E (fifo_rd=1, fifo_empty=0) presents the popped byte on fifo_data during the cycle after E.
REQ-015 The block SHALL be a two-state FSM: FILL (gather bytes) and OUT (present word).
REQ-016 In FILL, fifo_rd SHALL be combinational: fifo_rd = !fifo_empty && (issued < WORD_BYTES) && !flush_pend.
REQ-017 fifo_rd SHALL never be 1 while fifo_empty=1 and SHALL be 0 in OUT.
REQ-018 A one-bit in-flight flag SHALL register each issued pop; when set, fifo_data SHALL be written into lane captured, and captured SHALL increment.
REQ-019 Continuous non-empty fifo: fifo_rd high in cycles c..c+WORD_BYTES-1; m_valid high from cycle c+WORD_BYTES+1.
REQ-020 FILL->OUT occurs at the edge capturing byte WORD_BYTES, with m_bytes=WORD_BYTES.
REQ-021 In OUT, m_data, m_bytes and m_valid SHALL hold stable until an edge with m_ready=1.
REQ-022 On that handshake edge: words_out+1 (wraps 0xFFFF->0x0000); lanes and counters clear; state returns to FILL.
REQ-023 flush in FILL with captured>=1 and no pop in flight: next edge -> OUT, m_bytes=captured, unused lanes 0.
REQ-024 flush with a pop in flight: set flush_pend, block new pops, and emit after the in-flight capture.
REQ-025 flush with captured=0 and nothing in flight: ignored. flush in OUT: ignored.
REQ-026 fifo_empty rising mid-word: gathering pauses and resumes with no byte loss or duplication.

Reset
REQ-027 On reset_n=0, outputs SHALL be: m_valid=0, m_data=0, m_bytes=0, words_out=0, fifo_rd=0.
REQ-028 On reset_n=0: state=FILL, captured=0, issued=0, in-flight=0, flush_pend=0.
REQ-029 A byte popped before a mid-operation reset is discarded; this is accepted behaviour.

Structure
REQ-030 Shared package fifo_rd_pkg SHALL hold the state enum typedef (FILL, OUT) and constant FIFO_DW=8.
REQ-031 One sub-module, word_pack, SHALL hold the lane registers, write-by-index and clear.
REQ-032 All other logic (FSM, counters, flag) SHALL live in fifo_word_reader.

Verification
REQ-033 Scenario: fifo preloaded with 0x11,0x22,0x33,0x44, m_ready=1.
  Required: words 0x2211 then 0x4433, m_bytes=2, words_out=2, and fifo_rd never high while empty.
REQ-034 Scenario: fifo preloaded with 0xA5,0x5A, m_ready=0 for 10 cycles.
  Required: m_data=0x5AA5 and m_valid=1 held for all 10 cycles, fifo_rd=0 throughout, accepted on the first m_ready=1 edge.
REQ-035 Scenario: write a single byte 0x7E, then pulse flush.
  Required: m_data=0x007E, m_bytes=1.
  Scenario: flush asserted in the cycle after the pop.
  Required: same result, with no second pop.
REQ-036 Scenario: bytes 0x01, gap of 5 empty cycles, then 0x02.
  Required: one word 0x0201 with no duplicate or lost byte.
REQ-037 Scenario: assert reset_n=0 while in OUT holding 0xBEEF.
  Required: m_valid, m_data and words_out return to 0 immediately; the next word after reset is built from fresh fifo data.
REQ-038 Scenario: preload words_out to 0xFFFF via 65535 transfers (or a force), then accept one more word.
  Required: words_out=0x0000.
